// File: rtl/music_pkg.sv
// Shared MIDI field widths, play-mode encodings, FSM state codes and the
// transpose/saturate helper used by the step sequencer.
package music_pkg;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam logic [NOTE_W-1:0] NOTE_MAX = 7'd127;

  localparam logic [1:0] MODE_FWD = 2'd0;
  localparam logic [1:0] MODE_REV = 2'd1;
  localparam logic [1:0] MODE_PP  = 2'd2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_OFF   = 3'd2;
  localparam logic [2:0] ST_ON    = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // Signed semitone offset, clamped to the MIDI note range.
  function automatic logic [NOTE_W-1:0] transpose_note(input logic [NOTE_W-1:0] note,
                                                       input logic [7:0] semis);
    logic signed [9:0] sum;
    sum = $signed({3'b000, note}) + $signed({{2{semis[7]}}, semis});
    if (sum < 10'sd0)        return '0;
    else if (sum > 10'sd127) return NOTE_MAX;
    else                     return sum[NOTE_W-1:0];
  endfunction
endpackage

// File: rtl/step_sequencer_if.sv
// Note event channel from the sequencer to a synth voice or MIDI transmitter.
interface step_sequencer_if;
  import music_pkg::*;
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_on;
  logic [NOTE_W-1:0] evt_note;
  logic [VEL_W-1:0]  evt_vel;

  modport master (output evt_valid, evt_on, evt_note, evt_vel, input evt_ready);
  modport slave  (input evt_valid, evt_on, evt_note, evt_vel, output evt_ready);
endinterface

// File: rtl/step_ram.sv
// Step storage: simple dual-port RAM, synchronous read, read-first on collision.
module step_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/step_sequencer.sv
// Programmable step sequencer: plays RAM steps on tempo strobes and emits
// note-on/note-off events over a valid/ready channel.
//   state    | meaning
//   IDLE     | stopped, nothing sounding
//   FETCH    | step data arriving from RAM, transpose applied
//   OFF      | note-off for the sounding note presented
//   ON       | note-on for the new step presented
//   HOLD     | note sounding (or rest), counting gate, waiting for step_tick
module step_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int GATE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_tick,
  input  logic              sub_tick,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] loop_last,
  input  logic [7:0]        transpose,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [VEL_W-1:0]  wr_vel,
  input  logic [GATE_W-1:0] wr_gate,
  step_sequencer_if.master  evt,
  output logic [ADDR_W-1:0] cur_step,
  output logic              playing,
  output logic              overrun
);
  localparam int DATA_W = NOTE_W + VEL_W + GATE_W;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx, nxt_idx, start_idx, rd_addr;
  logic              dir_down, nxt_down, pend, sounding, after_on;
  logic [NOTE_W-1:0] snd_note, st_note, q_note, fetch_note;
  logic [VEL_W-1:0]  st_vel, q_vel;
  logic [GATE_W-1:0] st_gate, q_gate, gate_cnt;
  logic [DATA_W-1:0] rd_data;
  logic              tick_now, expire, advance, fetch_go;

  assign {q_note, q_vel, q_gate} = rd_data;
  assign fetch_note = transpose_note(q_note, transpose);
  assign start_idx  = (mode == MODE_REV) ? loop_last : '0;
  assign tick_now   = step_tick | pend;
  assign expire     = sounding && sub_tick && (gate_cnt == GATE_W'(1));
  assign advance    = (state == ST_HOLD) && run && !expire && tick_now;
  assign fetch_go   = ((state == ST_IDLE) && run) || advance;
  assign rd_addr    = (state == ST_IDLE) ? start_idx : nxt_idx;
  assign playing    = (state != ST_IDLE);

  step_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_note, wr_vel, wr_gate}),
    .rd_en   (fetch_go),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Ping-pong turns at the ends without replaying the endpoint.
  always_comb begin
    nxt_idx  = idx;
    nxt_down = dir_down;
    if (idx > loop_last) begin
      nxt_idx  = '0;
      nxt_down = 1'b0;
    end else begin
      case (mode)
        MODE_REV: nxt_idx = (idx == '0) ? loop_last : idx - ADDR_W'(1);
        MODE_PP: begin
          if (loop_last == '0) begin
            nxt_idx = '0;
          end else if (!dir_down) begin
            if (idx == loop_last) begin
              nxt_idx  = idx - ADDR_W'(1);
              nxt_down = 1'b1;
            end else begin
              nxt_idx = idx + ADDR_W'(1);
            end
          end else begin
            if (idx == '0) begin
              nxt_idx  = ADDR_W'(1);
              nxt_down = 1'b0;
            end else begin
              nxt_idx = idx - ADDR_W'(1);
            end
          end
        end
        default: nxt_idx = (idx == loop_last) ? '0 : idx + ADDR_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cur_step      <= '0;
      dir_down      <= 1'b0;
      pend          <= 1'b0;
      overrun       <= 1'b0;
      sounding      <= 1'b0;
      after_on      <= 1'b0;
      snd_note      <= '0;
      st_note       <= '0;
      st_vel        <= '0;
      st_gate       <= '0;
      gate_cnt      <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_on    <= 1'b0;
      evt.evt_note  <= '0;
      evt.evt_vel   <= '0;
    end else begin
      // A tick arriving together with a consumed pending tick stays pending.
      if (state == ST_IDLE) begin
        pend <= 1'b0;
      end else if (advance) begin
        pend <= pend & step_tick;
      end else if (step_tick) begin
        if (pend) overrun <= 1'b1;
        pend <= 1'b1;
      end

      case (state)
        ST_IDLE: if (run) begin
          idx      <= start_idx;
          cur_step <= start_idx;
          dir_down <= 1'b0;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          st_note <= fetch_note;
          st_vel  <= q_vel;
          st_gate <= q_gate;
          if (sounding) begin
            evt.evt_valid <= 1'b1;
            evt.evt_on    <= 1'b0;
            evt.evt_note  <= snd_note;
            evt.evt_vel   <= '0;
            after_on      <= 1'b1;
            state         <= ST_OFF;
          end else if (!run) begin
            state <= ST_IDLE;
          end else if (q_vel != '0) begin
            evt.evt_valid <= 1'b1;
            evt.evt_on    <= 1'b1;
            evt.evt_note  <= fetch_note;
            evt.evt_vel   <= q_vel;
            state         <= ST_ON;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_OFF: if (evt.evt_ready) begin
          evt.evt_valid <= 1'b0;
          sounding      <= 1'b0;
          if (!run) begin
            state <= ST_IDLE;
          end else if (after_on && st_vel != '0) begin
            evt.evt_valid <= 1'b1;
            evt.evt_on    <= 1'b1;
            evt.evt_note  <= st_note;
            evt.evt_vel   <= st_vel;
            state         <= ST_ON;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_ON: if (evt.evt_ready) begin
          evt.evt_valid <= 1'b0;
          sounding      <= 1'b1;
          snd_note      <= evt.evt_note;
          gate_cnt      <= st_gate;
          if (!run) begin
            evt.evt_valid <= 1'b1;
            evt.evt_on    <= 1'b0;
            evt.evt_vel   <= '0;
            after_on      <= 1'b0;
            state         <= ST_OFF;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if ((!run && sounding) || (run && expire)) begin
            evt.evt_valid <= 1'b1;
            evt.evt_on    <= 1'b0;
            evt.evt_note  <= snd_note;
            evt.evt_vel   <= '0;
            after_on      <= 1'b0;
            state         <= ST_OFF;
          end else if (!run) begin
            state <= ST_IDLE;
          end else begin
            if (sub_tick && gate_cnt != '0) gate_cnt <= gate_cnt - GATE_W'(1);
            if (tick_now) begin
              idx      <= nxt_idx;
              dir_down <= nxt_down;
              cur_step <= nxt_idx;
              state    <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: expected events are queued as stimulus is
// driven and matched against each accepted event.
module tb_step_sequencer;
  import music_pkg::*;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } evt_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic       step_tick = 1'b0, sub_tick = 1'b0, run = 1'b0;
  logic [1:0] mode = MODE_FWD;
  logic [2:0] loop_last = 3'd7;
  logic [7:0] transpose = 8'd0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [6:0] wr_note = 7'd0, wr_vel = 7'd0;
  logic [3:0] wr_gate = 4'd0;
  logic [2:0] cur_step;
  logic       playing, overrun;

  step_sequencer_if evt_bus ();

  step_sequencer #(.ADDR_W(3), .GATE_W(4)) dut (
    .clk(clk), .reset(reset), .step_tick(step_tick), .sub_tick(sub_tick), .run(run),
    .mode(mode), .loop_last(loop_last), .transpose(transpose), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_vel(wr_vel), .wr_gate(wr_gate),
    .evt(evt_bus), .cur_step(cur_step), .playing(playing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  evt_t sb[$];
  int   checks = 0, errors = 0;
  logic [6:0] scale [8] = '{7'd60, 7'd62, 7'd63, 7'd65, 7'd67, 7'd68, 7'd70, 7'd72};
  int   pp_order [8] = '{1, 2, 3, 2, 1, 0, 1, 2};

  function automatic evt_t ev_on(input logic [6:0] n);
    return {1'b1, n, 7'd100};
  endfunction
  function automatic evt_t ev_off(input logic [6:0] n);
    return {1'b0, n, 7'd0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_step(input logic [2:0] a, input logic [6:0] n, input logic [6:0] v,
                            input logic [3:0] g);
    wr_addr = a; wr_note = n; wr_vel = v; wr_gate = g; wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_step();
    step_tick = 1'b1; cyc(1); step_tick = 1'b0;
  endtask

  task automatic pulse_sub();
    sub_tick = 1'b1; cyc(1); sub_tick = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  // Scoreboard: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    evt_t got, exp;
    if (evt_bus.evt_valid && evt_bus.evt_ready) begin
      got = {evt_bus.evt_on, evt_bus.evt_note, evt_bus.evt_vel};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL evt_unexpected observed=%0h expected=none", got);
      end else begin
        exp = sb.pop_front();
        assert (got === exp) else begin
          errors++;
          $error("FAIL evt observed=%0h expected=%0h", got, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    evt_bus.evt_ready = 1'b1;
    cyc(2);
    chk("rst_valid", evt_bus.evt_valid, 0);
    chk("rst_fields", {evt_bus.evt_on, evt_bus.evt_note, evt_bus.evt_vel}, 0);
    chk("rst_cur_playing_ovr", {cur_step, playing, overrun}, 0);
    reset = 1'b0;
    cyc(1);

    // Forward play over the scale, then stop while 65 sounds.
    for (int i = 0; i < 8; i++) write_step(3'(i), scale[i], 7'd100, 4'd0);
    sb.push_back(ev_on(7'd60));
    run = 1'b1;
    cyc(4);
    drain("fwd_start");
    chk("fwd_cur0", cur_step, 0);
    for (int k = 1; k < 4; k++) begin
      sb.push_back(ev_off(scale[k-1]));
      sb.push_back(ev_on(scale[k]));
      pulse_step();
      cyc(4);
      drain("fwd_step");
      chk("fwd_cur", cur_step, 32'(k));
    end
    sb.push_back(ev_off(7'd65));
    run = 1'b0;
    cyc(4);
    drain("stop_off65");
    chk("stop_playing", playing, 0);

    // Ping-pong over steps 0..3.
    mode = MODE_PP; loop_last = 3'd3;
    sb.push_back(ev_on(7'd60));
    run = 1'b1;
    cyc(4);
    drain("pp_start");
    for (int k = 0; k < 8; k++) begin
      sb.push_back(ev_off(scale[(k == 0) ? 0 : pp_order[k-1]]));
      sb.push_back(ev_on(scale[pp_order[k]]));
      pulse_step();
      cyc(4);
      drain("pp_step");
      chk("pp_cur", cur_step, 32'(pp_order[k]));
    end
    sb.push_back(ev_off(7'd63));
    run = 1'b0;
    cyc(4);
    drain("pp_stop");

    // Reverse over steps 0..2, starting at loop_last.
    mode = MODE_REV; loop_last = 3'd2;
    sb.push_back(ev_on(7'd63));
    run = 1'b1;
    cyc(4);
    drain("rev_start");
    chk("rev_cur_start", cur_step, 2);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(ev_off(scale[(k == 0) ? 2 : 2 - k]));
      sb.push_back(ev_on(scale[(k == 2) ? 2 : 1 - k]));
      pulse_step();
      cyc(4);
      drain("rev_step");
    end
    chk("rev_cur_wrap", cur_step, 2);
    sb.push_back(ev_off(7'd63));
    run = 1'b0;
    cyc(4);
    drain("rev_stop");

    // Transpose saturation at both ends.
    mode = MODE_FWD; loop_last = 3'd0;
    write_step(3'd0, 7'd72, 7'd100, 4'd0);
    transpose = 8'd70;
    sb.push_back(ev_on(7'd127));
    run = 1'b1;
    cyc(4);
    drain("tr_hi_on");
    sb.push_back(ev_off(7'd127));
    run = 1'b0;
    cyc(4);
    drain("tr_hi_off");
    write_step(3'd0, 7'd60, 7'd100, 4'd0);
    transpose = 8'h80;
    sb.push_back(ev_on(7'd0));
    run = 1'b1;
    cyc(4);
    drain("tr_lo_on");
    sb.push_back(ev_off(7'd0));
    run = 1'b0;
    cyc(4);
    drain("tr_lo_off");
    transpose = 8'd0;

    // Gate length 2 and a rest after a legato note.
    write_step(3'd0, 7'd60, 7'd100, 4'd2);
    write_step(3'd1, 7'd63, 7'd100, 4'd0);
    write_step(3'd2, 7'd62, 7'd0, 4'd0);
    loop_last = 3'd2;
    sb.push_back(ev_on(7'd60));
    run = 1'b1;
    cyc(4);
    drain("gate_on");
    pulse_sub();
    cyc(3);
    chk("gate_mid_valid", evt_bus.evt_valid, 0);
    sb.push_back(ev_off(7'd60));
    pulse_sub();
    cyc(3);
    drain("gate_off");
    chk("gate_playing", playing, 1);
    sb.push_back(ev_on(7'd63));
    pulse_step();
    cyc(4);
    drain("legato_on");
    sb.push_back(ev_off(7'd63));
    pulse_step();
    cyc(4);
    drain("rest_off");
    cyc(2);
    chk("rest_cur_valid", {cur_step, evt_bus.evt_valid}, {3'd2, 1'b0});
    run = 1'b0;
    cyc(4);
    chk("rest_stop_playing", playing, 0);

    // Backpressure: fields hold, two ticks while busy set overrun.
    write_step(3'd0, 7'd60, 7'd100, 4'd0);
    write_step(3'd1, 7'd62, 7'd100, 4'd0);
    loop_last = 3'd7;
    evt_bus.evt_ready = 1'b0;
    sb.push_back(ev_on(7'd60));
    run = 1'b1;
    cyc(3);
    for (int i = 0; i < 20; i++) begin
      step_tick = (i == 3 || i == 8);
      chk("bp_stable", {evt_bus.evt_valid, evt_bus.evt_on, evt_bus.evt_note, evt_bus.evt_vel},
          {1'b1, 1'b1, 7'd60, 7'd100});
      cyc(1);
    end
    step_tick = 1'b0;
    chk("bp_overrun", overrun, 1);
    sb.push_back(ev_off(7'd60));
    sb.push_back(ev_on(7'd62));
    evt_bus.evt_ready = 1'b1;
    cyc(4);
    drain("bp_release");
    chk("bp_cur", cur_step, 1);
    sb.push_back(ev_off(7'd62));
    run = 1'b0;
    cyc(4);
    drain("bp_stop");
    chk("bp_overrun_sticky", overrun, 1);

    // Reset in HOLD: everything clears at once, no note-off follows.
    mode = MODE_REV; loop_last = 3'd1;
    sb.push_back(ev_on(7'd62));
    run = 1'b1;
    cyc(4);
    drain("hold_on");
    chk("hold_state", {cur_step, playing}, {3'd1, 1'b1});
    reset = 1'b1;
    run = 1'b0;
    #1;
    chk("rst_hold_valid", evt_bus.evt_valid, 0);
    chk("rst_hold_fields", {evt_bus.evt_on, evt_bus.evt_note, evt_bus.evt_vel}, 0);
    chk("rst_hold_cur_playing_ovr", {cur_step, playing, overrun}, 0);
    cyc(2);
    reset = 1'b0;
    cyc(5);
    chk("post_rst_quiet", {evt_bus.evt_valid, playing}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
